// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester APB master with round-robin arbitration.
// One APB bus is shared by requester 0 and requester 1. Each transfer runs
// through SETUP and ACCESS, and PADDR[SEL_BIT] picks slave 1 or slave 2.
// Optional build macro TIMEOUT_EN: when it is defined, an ACCESS phase that
// sees no PREADY for TIMEOUT_CYC cycles is aborted. The aborted requester gets
// req_done together with req_err, and rdata is forced to zero.
module apb_master_arb #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SEL_BIT     = 7,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_done,
  output logic [1:0]          req_err,
  output logic [DATA_W-1:0]   rdata,
  output logic                PSEL1,
  output logic                PSEL2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA1,
  input  logic [DATA_W-1:0]   PRDATA2,
  input  logic                PREADY1,
  input  logic                PREADY2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_r;
  logic                last_grant_r;  // requester granted most recently
  logic                grant_r;       // requester owning the bus now

  logic [1:0]          eligible_s;
  logic                grant_vld_s;
  logic                grant_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_wdata_s;
  logic                win_write_s;
  logic                sel_ready_s;
  logic [DATA_W-1:0]   sel_rdata_s;

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    wait_cnt_r;
  logic                timeout_s;

  // The limit is reached while the current ACCESS cycle still sees no PREADY.
  always_comb begin
    timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  end
`endif

  // Round-robin arbitration. A requester whose done pulse is high right now is
  // masked, so a valid that is still high from the last transfer is not regranted.
  always_comb begin
    eligible_s  = req_valid & ~req_done;
    grant_vld_s = |eligible_s;
    if (eligible_s == 2'b11) begin
      grant_s = ~last_grant_r;
    end else if (eligible_s[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Select the address, data and direction of the requester that wins.
  always_comb begin
    if (grant_s) begin
      win_addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
      win_wdata_s = req_wdata[2*DATA_W-1:DATA_W];
      win_write_s = req_write[1];
    end else begin
      win_addr_s  = req_addr[ADDR_W-1:0];
      win_wdata_s = req_wdata[DATA_W-1:0];
      win_write_s = req_write[0];
    end
  end

  // Use only the selected slave's response. The other slave is ignored.
  always_comb begin
    if (PSEL2) begin
      sel_ready_s = PREADY2;
      sel_rdata_s = PRDATA2;
    end else begin
      sel_ready_s = PREADY1;
      sel_rdata_s = PRDATA1;
    end
  end

  // Transfer sequencer. All bus and requester-side outputs are registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      PSEL1        <= 1'b0;
      PSEL2        <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= {ADDR_W{1'b0}};
      PWDATA       <= {DATA_W{1'b0}};
      rdata        <= {DATA_W{1'b0}};
      req_done     <= 2'b00;
      req_err      <= 2'b00;
`ifdef TIMEOUT_EN
      wait_cnt_r   <= {CNT_W{1'b0}};
`endif
    end else begin
      req_done <= 2'b00;
      req_err  <= 2'b00;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            PADDR        <= win_addr_s;
            PWDATA       <= win_wdata_s;
            PWRITE       <= win_write_s;
            PSEL1        <= ~win_addr_s[SEL_BIT];
            PSEL2        <= win_addr_s[SEL_BIT];
            PENABLE      <= 1'b0;
            grant_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
`ifdef TIMEOUT_EN
          wait_cnt_r <= {CNT_W{1'b0}};
`endif
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready_s) begin
            PSEL1    <= 1'b0;
            PSEL2    <= 1'b0;
            PENABLE  <= 1'b0;
            req_done <= grant_r ? 2'b10 : 2'b01;
            if (!PWRITE) begin
              rdata <= sel_rdata_s;
            end
            state_r <= IDLE;
          end
`ifdef TIMEOUT_EN
          else if (timeout_s) begin
            PSEL1    <= 1'b0;
            PSEL2    <= 1'b0;
            PENABLE  <= 1'b0;
            req_done <= grant_r ? 2'b10 : 2'b01;
            req_err  <= grant_r ? 2'b10 : 2'b01;
            rdata    <= {DATA_W{1'b0}};
            state_r  <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
`endif
        end
        default: begin
          PSEL1   <= 1'b0;
          PSEL2   <= 1'b0;
          PENABLE <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Testbench for apb_master_arb. It uses randomized requests and slave responses,
// and checks the DUT against a transaction-level arbitration and timing model.
module tb_apb_master_arb;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 15;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [1:0]      req_valid, req_write, req_done, req_err;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, PWDATA, PRDATA1, PRDATA2;
  logic [AW-1:0]   PADDR;
  logic            PSEL1, PSEL2, PENABLE, PWRITE, PREADY1, PREADY2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] cur_addr [2];
  logic [DW-1:0] cur_wdata [2];
  logic          cur_write [2];
  int            rem [2];      // transfers still owed per requester
  int            last_g;       // last granted requester
  int            pend_g;       // requester whose done pulse was just seen, -1 if none
  logic [DW-1:0] rdata_exp;

  apb_master_arb dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  initial forever #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic noise();
    PREADY1 = 1'($urandom);
    PREADY2 = 1'($urandom);
    PRDATA1 = 8'($urandom);
    PRDATA2 = 8'($urandom);
  endtask

  task automatic apply_req(input int r);
    req_addr[r*AW +: AW]  = cur_addr[r];
    req_wdata[r*DW +: DW] = cur_wdata[r];
    req_write[r]          = cur_write[r];
    req_valid[r]          = (rem[r] > 0);
  endtask

  task automatic new_payload(input int r);
    cur_addr[r]  = 8'($urandom);
    cur_wdata[r] = 8'($urandom);
    cur_write[r] = 1'($urandom);
    apply_req(r);
  endtask

  // In the cycle after its done pulse, a requester either drops valid or posts its next request.
  task automatic settle_pending();
    if (pend_g >= 0) begin
      if (rem[pend_g] > 0) new_payload(pend_g);
      else req_valid[pend_g] = 1'b0;
      pend_g = -1;
    end
  endtask

  // Arbitration rule: the requester that just finished yields. Under contention, the one not granted last wins.
  task automatic next_grant(output int g, output int gap);
    if (pend_g >= 0) begin
      if (rem[1 - pend_g] > 0) begin g = 1 - pend_g; gap = 1; end
      else begin g = pend_g; gap = 2; end
    end else begin
      if (rem[0] > 0 && rem[1] > 0) g = 1 - last_g;
      else g = (rem[0] > 0) ? 0 : 1;
      gap = 1;
    end
  endtask

  // A negative waits value means the slave never answers.
  task automatic do_transfer(input int waits);
    int g, gap, n, last_i;
    logic seen, sel2, abort, ready;
    next_grant(g, gap);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 6) begin
      @(negedge PCLK);
      n++;
      seen = PSEL1 | PSEL2;
      settle_pending();
      noise();
    end
    check_eq("grant_gap", n, gap);
    if (!seen) return;
    sel2 = cur_addr[g][7];
    check_eq("setup_psel1", PSEL1, !sel2);
    check_eq("setup_psel2", PSEL2, sel2);
    check_eq("setup_penable", PENABLE, 1'b0);
    check_eq("setup_paddr", PADDR, cur_addr[g]);
    check_eq("setup_pwrite", PWRITE, cur_write[g]);
    check_eq("setup_pwdata", PWDATA, cur_wdata[g]);
    check_eq("setup_done", req_done, 2'b00);
    last_g = g;
    rem[g]--;
`ifdef TIMEOUT_EN
    abort = (waits < 0) || (waits >= TMO);
`else
    abort = 1'b0;
`endif
    last_i = abort ? TMO - 1 : waits;
    for (int i = 0; i <= last_i; i++) begin
      @(negedge PCLK);
      check_eq("acc_penable", PENABLE, 1'b1);
      check_eq("acc_psel", {PSEL2, PSEL1}, sel2 ? 2'b10 : 2'b01);
      check_eq("acc_paddr", PADDR, cur_addr[g]);
      check_eq("acc_done", req_done, 2'b00);
      noise();
      ready = (i == waits);
      if (sel2) PREADY2 = ready;
      else PREADY1 = ready;
      if (ready && !cur_write[g]) rdata_exp = sel2 ? PRDATA2 : PRDATA1;
    end
    @(negedge PCLK);
    if (abort) rdata_exp = 8'h00;
    check_eq("done", req_done, (g == 1) ? 2'b10 : 2'b01);
    check_eq("err", req_err, abort ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00);
    check_eq("rdata", rdata, rdata_exp);
    check_eq("done_bus_idle", {PSEL2, PSEL1, PENABLE}, 3'b000);
    pend_g = g;
    noise();
  endtask

  task automatic tail();
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check_eq("tail_idle", {PSEL2, PSEL1, PENABLE}, 3'b000);
      if (i == 0) check_eq("done_pulse", req_done, 2'b00);
      settle_pending();
      noise();
    end
  endtask

  task automatic run_round(input int r0, input int r1, input int maxw);
    rem[0] = r0;
    rem[1] = r1;
    for (int r = 0; r < 2; r++) if (rem[r] > 0) new_payload(r);
    repeat (r0 + r1) do_transfer(int'($urandom_range(maxw, 0)));
    tail();
  endtask

  task automatic directed(input int r, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int waits);
    rem[r]       = 1;
    cur_write[r] = w;
    cur_addr[r]  = a;
    cur_wdata[r] = d;
    apply_req(r);
    do_transfer(waits);
    tail();
  endtask

  initial begin
    int n, mask, r0, r1;
    PRESET    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    noise();
    rem[0] = 0; rem[1] = 0;
    last_g = 1; pend_g = -1; rdata_exp = 8'h00;
    repeat (2) @(negedge PCLK);
    check_eq("rst_psel", {PSEL2, PSEL1, PENABLE, PWRITE}, 4'b0000);
    check_eq("rst_paddr", PADDR, 8'h00);
    check_eq("rst_pwdata", PWDATA, 8'h00);
    check_eq("rst_rdata", rdata, 8'h00);
    check_eq("rst_done", {req_done, req_err}, 4'b0000);
    PRESET = 1'b0;

    // req0 write to slave 1 with no wait states; req1 read from slave 2 with three wait states
    directed(0, 1'b1, 8'h05, 8'hA5, 0);
    directed(1, 1'b0, 8'h85, 8'h00, 3);

    // both requesters held for two transfers each: order 0,1,0,1
    run_round(2, 2, 0);

    // reset pulsed during ACCESS
    rem[0] = 1;
    cur_write[0] = 1'b0; cur_addr[0] = 8'h40; cur_wdata[0] = 8'h11;
    apply_req(0);
    n = 0;
    while (!PENABLE && n < 10) begin @(negedge PCLK); n++; end
    check_eq("rst_reach_access", PENABLE, 1'b1);
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    #2 PRESET = 1'b1;
    #1 check_eq("rst_async_bus", {PSEL2, PSEL1, PENABLE}, 3'b000);
    check_eq("rst_async_done", req_done, 2'b00);
    @(negedge PCLK);
    check_eq("rst_no_done", req_done, 2'b00);
    check_eq("rst_rdata_clr", rdata, 8'h00);
    PRESET = 1'b0;
    req_valid = 2'b00;
    rem[0] = 0; rem[1] = 0;
    last_g = 1; pend_g = -1; rdata_exp = 8'h00;
    run_round(1, 1, 1);

    // stalled slave 1: times out when enabled, otherwise waits 100 cycles
`ifdef TIMEOUT_EN
    directed(0, 1'b0, 8'h12, 8'h00, -1);
`else
    directed(0, 1'b0, 8'h12, 8'h00, 100);
`endif
    // PREADY arrives on the 15th ACCESS cycle
    directed(0, 1'b0, 8'h22, 8'h00, TMO - 1);

    // randomized rounds
    for (int k = 0; k < 24; k++) begin
      mask = int'($urandom_range(3, 1));
      r0 = (mask & 1) != 0 ? int'($urandom_range(2, 1)) : 0;
      r1 = (mask & 2) != 0 ? int'($urandom_range(2, 1)) : 0;
      run_round(r0, r1, 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
